// File: rtl/rv_pkg.sv
// Shared constants and types for the writeback/regfile path.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  // Writeback requesters; also used as the round-robin "who wins next conflict" pointer.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  // The requester that gets priority after `id` wins a conflict.
  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_ALU) ? REQ_LSU : REQ_ALU;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, register-file write port, scoreboard and hazard signals.
interface regfile_wb_arbiter_if #(
  parameter int XLEN     = rv_pkg::XLEN,
  parameter int NUM_REGS = rv_pkg::NUM_REGS
);

  localparam int AW = rv_pkg::REG_ADDR_W;

  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  logic            rf_write_en;
  logic [AW-1:0]   rf_wr_reg_num;
  logic [XLEN-1:0] rf_write_data;

  logic            rsv_en;
  logic [AW-1:0]   rsv_rd;
  logic [AW-1:0]   chk_rs1;
  logic [AW-1:0]   chk_rs2;
  logic [AW-1:0]   chk_rd;
  logic            hazard;

  logic            flush;
  logic [NUM_REGS-1:0] busy_vec;

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  rsv_en, rsv_rd, chk_rs1, chk_rs2, chk_rd, flush,
    output alu_ready, lsu_ready,
    output rf_write_en, rf_wr_reg_num, rf_write_data,
    output hazard, busy_vec
  );

  // Pipeline / environment side.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output rsv_en, rsv_rd, chk_rs1, chk_rs2, chk_rd, flush,
    input  alu_ready, lsu_ready,
    input  rf_write_en, rf_wr_reg_num, rf_write_data,
    input  hazard, busy_vec
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set by issue-stage reservation, cleared when the
// register's write pulse retires, wiped by flush. Provides the operand hazard.
module rf_scoreboard #(
  parameter int NUM_REGS   = rv_pkg::NUM_REGS,
  parameter int REG_ADDR_W = rv_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rsv_en_i,
  input  logic [REG_ADDR_W-1:0] rsv_rd_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_rd_i,
  input  logic                  flush_i,
  input  logic [REG_ADDR_W-1:0] chk_rs1_i,
  input  logic [REG_ADDR_W-1:0] chk_rs2_i,
  input  logic [REG_ADDR_W-1:0] chk_rd_i,
  output logic                  hazard_o,
  output logic [NUM_REGS-1:0]   busy_vec_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // x0 is never tracked, so index 0 always reads as free.
  function automatic logic is_busy(input logic [NUM_REGS-1:0] vec,
                                   input logic [REG_ADDR_W-1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == REG_ADDR_W'(i)) hit = vec[i];
    end
    return hit;
  endfunction

  // Next busy state: flush wipes everything; otherwise retire first, then reserve so a same-edge reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (clr_en_i && (clr_rd_i == REG_ADDR_W'(i))) busy_d[i] = 1'b0;
        if (rsv_en_i && (rsv_rd_i == REG_ADDR_W'(i))) busy_d[i] = 1'b1;
      end
    end
  end

  // Busy bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Hazard straight off the registered bits: no bypass of the retiring write.
  always_comb begin
    hazard_o = is_busy(busy_q, chk_rs1_i) ||
               is_busy(busy_q, chk_rs2_i) ||
               is_busy(busy_q, chk_rd_i);
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter between ALU and LSU writeback onto a single register-file
// write port, registered with one cycle of latency, plus the busy scoreboard.
module regfile_wb_arbiter #(
  parameter int NUM_REGS = rv_pkg::NUM_REGS,
  parameter int XLEN     = rv_pkg::XLEN
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_arbiter_if.slave bus
);

  localparam int AW = rv_pkg::REG_ADDR_W;

  rv_pkg::req_id_e rr_q, rr_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_num_q, wr_num_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;

  logic alu_ready, lsu_ready;
  logic alu_acc, lsu_acc;

  // Ready depends only on the other requester and the pointer, never on the requester's own valid.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (rst_n && !bus.flush) begin
      alu_ready = !bus.lsu_valid || (rr_q == rv_pkg::REQ_ALU);
      lsu_ready = !bus.alu_valid || (rr_q == rv_pkg::REQ_LSU);
    end
  end

  // Grant capture and pointer advance; the pointer moves only on a real conflict.
  always_comb begin
    alu_acc   = bus.alu_valid && alu_ready;
    lsu_acc   = bus.lsu_valid && lsu_ready;
    rr_d      = rr_q;
    wr_en_d   = 1'b0;
    wr_num_d  = wr_num_q;
    wr_data_d = wr_data_q;

    if (bus.alu_valid && bus.lsu_valid && !bus.flush) begin
      rr_d = rv_pkg::other_req(lsu_acc ? rv_pkg::REQ_LSU : rv_pkg::REQ_ALU);
    end

    // A write to x0 completes the handshake but never reaches the port; data/num hold.
    if (lsu_acc) begin
      if (bus.lsu_rd != '0) begin
        wr_en_d   = 1'b1;
        wr_num_d  = bus.lsu_rd;
        wr_data_d = bus.lsu_data;
      end
    end else if (alu_acc) begin
      if (bus.alu_rd != '0) begin
        wr_en_d   = 1'b1;
        wr_num_d  = bus.alu_rd;
        wr_data_d = bus.alu_data;
      end
    end
  end

  // Round-robin pointer and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= rv_pkg::REQ_LSU;
      wr_en_q   <= 1'b0;
      wr_num_q  <= '0;
      wr_data_q <= '0;
    end else begin
      rr_q      <= rr_d;
      wr_en_q   <= wr_en_d;
      wr_num_q  <= wr_num_d;
      wr_data_q <= wr_data_d;
    end
  end

  rf_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .REG_ADDR_W (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .rsv_en_i   (bus.rsv_en),
    .rsv_rd_i   (bus.rsv_rd),
    .clr_en_i   (wr_en_q),
    .clr_rd_i   (wr_num_q),
    .flush_i    (bus.flush),
    .chk_rs1_i  (bus.chk_rs1),
    .chk_rs2_i  (bus.chk_rs2),
    .chk_rd_i   (bus.chk_rd),
    .hazard_o   (bus.hazard),
    .busy_vec_o (bus.busy_vec)
  );

  assign bus.alu_ready     = alu_ready;
  assign bus.lsu_ready     = lsu_ready;
  assign bus.rf_write_en   = wr_en_q;
  assign bus.rf_wr_reg_num = wr_num_q;
  assign bus.rf_write_data = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random checks of regfile_wb_arbiter against a cycle-level model.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: busy set, who won the last conflict, and the pending write port contents.
  logic [31:0] m_busy;
  logic        m_last_lsu;
  logic        m_wr_en;
  logic [4:0]  m_num;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy     = '0;
    m_last_lsu = 1'b0;
    m_wr_en    = 1'b0;
    m_num      = '0;
    m_data     = '0;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.rsv_en = 1'b0; bus.rsv_rd = '0;
    bus.chk_rs1 = '0; bus.chk_rs2 = '0; bus.chk_rd = '0;
    bus.flush = 1'b0;
  endtask

  function automatic logic reg_busy(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r];
  endfunction

  // Called at a falling edge with inputs already driven; checks combinational outputs,
  // advances the model across the rising edge and checks registered outputs.
  task automatic tick(input string tag);
    logic ar, lr, lsu_turn, acc_a, acc_l;
    logic [31:0] nb;
    #1;
    if (!rst_n || bus.flush) begin
      ar = 1'b0;
      lr = 1'b0;
    end else begin
      lsu_turn = !m_last_lsu;
      ar = !(bus.lsu_valid && lsu_turn);
      lr = !(bus.alu_valid && !lsu_turn);
    end
    check({tag, ".alu_ready"}, bus.alu_ready, ar);
    check({tag, ".lsu_ready"}, bus.lsu_ready, lr);
    check({tag, ".hazard"}, bus.hazard,
          reg_busy(bus.chk_rs1) || reg_busy(bus.chk_rs2) || reg_busy(bus.chk_rd));
    acc_a = bus.alu_valid && ar;
    acc_l = bus.lsu_valid && lr;

    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (bus.alu_valid && bus.lsu_valid && !bus.flush) m_last_lsu = acc_l;
      nb = m_busy;
      if (bus.flush) begin
        nb = '0;
      end else begin
        if (m_wr_en) nb[m_num] = 1'b0;
        if (bus.rsv_en && bus.rsv_rd != 5'd0) nb[bus.rsv_rd] = 1'b1;
      end
      m_busy = nb;
      if (acc_l) begin
        m_wr_en = (bus.lsu_rd != 5'd0);
        if (m_wr_en) begin m_num = bus.lsu_rd; m_data = bus.lsu_data; end
      end else if (acc_a) begin
        m_wr_en = (bus.alu_rd != 5'd0);
        if (m_wr_en) begin m_num = bus.alu_rd; m_data = bus.alu_data; end
      end else begin
        m_wr_en = 1'b0;
      end
    end
    #1;
    check({tag, ".rf_write_en"}, bus.rf_write_en, m_wr_en);
    check({tag, ".rf_wr_reg_num"}, bus.rf_wr_reg_num, m_num);
    check({tag, ".rf_write_data"}, bus.rf_write_data, m_data);
    check({tag, ".busy_vec"}, bus.busy_vec, m_busy);
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] exp_num [4];
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);

    // Reset: outputs zero and no ready even with requests pending.
    bus.alu_valid = 1'b1; bus.lsu_valid = 1'b1; bus.alu_rd = 5'd3; bus.lsu_rd = 5'd4;
    bus.rsv_en = 1'b1; bus.rsv_rd = 5'd6;
    tick("reset");
    check("reset.alu_ready_const", bus.alu_ready, 1'b0);
    idle_inputs();
    rst_n = 1'b1;
    tick("idle");

    // Single ALU writeback.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick("alu_single");
    check("alu_single.num_const", bus.rf_wr_reg_num, 5'd5);
    check("alu_single.data_const", bus.rf_write_data, 32'hDEADBEEF);
    idle_inputs();
    tick("alu_hold");

    // Sustained conflict: LSU, ALU, LSU, ALU.
    exp_num[0] = 5'd4; exp_num[1] = 5'd3; exp_num[2] = 5'd4; exp_num[3] = 5'd3;
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hA000_0000 + 32'(i);
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'hB000_0000 + 32'(i);
      tick("rr");
      check("rr.grant_order", bus.rf_wr_reg_num, exp_num[i]);
      check("rr.one_write", bus.rf_write_en, 1'b1);
    end
    idle_inputs();
    tick("rr_drain");

    // Reserve x7, watch hazard through the write pulse.
    bus.rsv_en = 1'b1; bus.rsv_rd = 5'd7;
    tick("rsv7");
    bus.rsv_en = 1'b0; bus.chk_rs1 = 5'd7;
    tick("haz7_wait");
    check("haz7.busy7", bus.busy_vec[7], 1'b1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
    tick("haz7_accept");
    bus.alu_valid = 1'b0;
    tick("haz7_pulse");
    check("haz7.cleared", bus.hazard, 1'b0);
    idle_inputs();

    // Write to x0 and reservation of x0.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1;
    bus.rsv_en = 1'b1; bus.rsv_rd = 5'd0;
    tick("x0");
    check("x0.no_write", bus.rf_write_en, 1'b0);
    check("x0.busy_zero", bus.busy_vec, 32'h0);
    idle_inputs();

    // Re-reservation of x9 at the edge its write retires.
    bus.rsv_en = 1'b1; bus.rsv_rd = 5'd9;
    tick("rsv9");
    bus.rsv_en = 1'b0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
    tick("wr9_accept");
    bus.lsu_valid = 1'b0;
    bus.rsv_en = 1'b1; bus.rsv_rd = 5'd9;
    tick("wr9_retire_rsv");
    check("rsv9.kept", bus.busy_vec[9], 1'b1);
    idle_inputs();

    // Flush with several registers busy and an LSU request pending.
    for (int r = 8; r <= 11; r++) begin
      bus.rsv_en = 1'b1; bus.rsv_rd = 5'(r);
      tick("rsv_f00");
    end
    check("flush.pre_busy", bus.busy_vec, 32'h0000_0F00);
    bus.rsv_en = 1'b1; bus.rsv_rd = 5'd12;
    bus.flush = 1'b1; bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd10; bus.lsu_data = 32'hF1;
    tick("flush");
    check("flush.busy_zero", bus.busy_vec, 32'h0);
    check("flush.no_write", bus.rf_write_en, 1'b0);
    idle_inputs();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      bus.alu_valid = 1'($urandom_range(0, 1));
      bus.alu_rd    = 5'($urandom_range(0, 15));
      bus.alu_data  = $urandom;
      bus.lsu_valid = 1'($urandom_range(0, 1));
      bus.lsu_rd    = 5'($urandom_range(0, 15));
      bus.lsu_data  = $urandom;
      bus.rsv_en    = 1'($urandom_range(0, 1));
      bus.rsv_rd    = 5'($urandom_range(0, 15));
      bus.chk_rs1   = 5'($urandom_range(0, 15));
      bus.chk_rs2   = 5'($urandom_range(0, 15));
      bus.chk_rd    = 5'($urandom_range(0, 31));
      bus.flush     = ($urandom_range(0, 19) == 0);
      tick("rnd");
    end
    idle_inputs();

    // Reset asserted while a write is on the port and another request is pending.
    bus.rsv_en = 1'b1; bus.rsv_rd = 5'd12;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'hC0FFEE;
    tick("pre_rst");
    check("pre_rst.write", bus.rf_write_en, 1'b1);
    bus.rsv_en = 1'b0; bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd13; bus.lsu_data = 32'h13;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.rf_write_en", bus.rf_write_en, 1'b0);
    check("midrst.rf_wr_reg_num", bus.rf_wr_reg_num, 5'd0);
    check("midrst.rf_write_data", bus.rf_write_data, 32'h0);
    check("midrst.busy_vec", bus.busy_vec, 32'h0);
    check("midrst.lsu_ready", bus.lsu_ready, 1'b0);
    model_reset();
    @(negedge clk);
    tick("in_rst");
    idle_inputs();
    rst_n = 1'b1;
    tick("post_rst");
    check("post_rst.dropped", bus.rf_write_en, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
